qpsk_demod: RTL and testbench
=============================

QPSK_DEMOD -- requirements
Module: qpsk_demod

Interface
REQ-001 Parameters: none; all constants come from the shared package.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 sample_in  input  8  QPSK line sample, unsigned offset-binary, midscale 128.
REQ-005 in_valid  input  1  sample_in qualifier; one sample accepted per cycle when high.
REQ-006 ld  input  1  frame start; qualified by in_valid; marks the first sample of symbol 0 of a byte.
REQ-007 data_out  output  8  recovered byte.
REQ-008 data_valid  output  1  one-cycle pulse when data_out updates.
REQ-009 busy  output  1  high while a frame is in progress (state ACCUM).

Function
REQ-010 Sample period: SPS = 8 samples per symbol, 4 symbols per byte, 32 accepted samples per frame.
REQ-011 Sample conversion: each accepted sample is re-centred to signed 9-bit as x = sample_in - 128.
REQ-012 Reference tables are indexed by sample phase k = 0..7.
- COS_LUT = 127, 90, 0, -90, -127, -90, 0, 90.
- SIN_LUT = 0, 90, 127, 90, 0, -90, -127, -90.
- Both tables are signed 8-bit.
REQ-013 Correlation:
- i_acc += x*COS_LUT[k]; q_acc += x*SIN_LUT[k].
- Each product is signed 17-bit.
- Accumulators are signed 20-bit; overflow is not possible.
REQ-014 Bit decision at symbol end (k = 7 accepted), for symbol n:
- even bit = (i_acc > 0); odd bit = (q_acc > 0).
- An accumulator of exactly 0 decides bit 0.
- Bits are written as byte[2n] = even, byte[2n+1] = odd.
- Both accumulators then clear to 0.
REQ-015 State machine, IDLE:
- Samples are ignored.
- in_valid & ld goes to ACCUM with k = 0, n = 0, and that sample is accumulated.
REQ-016 State machine, ACCUM:
- k increments per accepted sample.
- On k = 7, k wraps to 0 and n increments.
- On the decision for n = 3, the state returns to IDLE.
REQ-017 in_valid low stalls the state, k, n and both accumulators; stall length is unlimited.
REQ-018 ld re-sync:
- in_valid & ld while in ACCUM abandons the partial frame (no data_valid).
- Accumulators, k and n restart, and that sample is accumulated as k = 0 of a new frame.
REQ-019 Output latency:
- data_valid pulses exactly one cycle after the cycle that accepts sample 31.
- data_out changes only in that same cycle.
- data_out holds its value until the next completed frame.
REQ-020 A frame completes back-to-back: ld together with the first sample after sample 31 starts the next frame with no gap cycle.

Reset
REQ-021 While rst is high at a clk edge:
- state becomes IDLE; k, n, i_acc, q_acc and the partial byte clear to 0.
- data_out = 0x00, data_valid = 0, busy = 0.
REQ-022 rst has priority over ld and in_valid.
- A reset mid-frame discards that frame.
- No data_valid is produced for the discarded frame.

Structure
REQ-023 The shared package qpsk_pkg holds:
- SPS = 8 and SYMS_PER_BYTE = 4;
- the COS_LUT and SIN_LUT constants;
- MIDSCALE = 128 and the accumulator width 20;
- the state enum (IDLE, ACCUM).
The existing modulator side shall use the same package tables.
REQ-024 Sub-module qpsk_correlator: one instance, holding the k-indexed tables, the two multiply-accumulates and the clear/stall controls. The top level holds the FSM, the symbol counter and the byte assembly.

Verification
REQ-025 Byte 0xFF: 32 samples, with ld on the first, each sample = 128 + round(44*(cos+sin)) at phase k. Required response: data_out = 0xFF and data_valid one cycle after the last sample.
REQ-026 All samples = 128 (zero correlation). Required response: data_out = 0x00, confirming the tie rule.
REQ-027 Byte 0xA5 (symbols 01, 01, 10, 10, LSB pair first) with in_valid deasserted for 3 random cycles within each symbol. Required response: data_out = 0xA5 and exactly one data_valid pulse.
REQ-028 ld reasserted at sample 13 of a 0x3C frame, followed by a full 0xC3 frame. Required response: a single data_valid with data_out = 0xC3.
REQ-029 rst asserted at sample 20. Required response: data_valid never pulses for that frame, busy = 0 the next cycle, and a following 0x5A frame decodes correctly.
REQ-030 Two back-to-back frames, 0x12 then 0xED, with no idle cycle. Required response: two data_valid pulses exactly 32 accepted samples apart with the correct values.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared QPSK constants: symbol timing, reference carrier tables, accumulator sizing and FSM states.
// The modulator side indexes the same COS_LUT/SIN_LUT, so the carrier definition lives in one place.
package qpsk_pkg;
  localparam int SPS           = 8;
  localparam int SYMS_PER_BYTE = 4;
  localparam int MIDSCALE      = 128;
  localparam int ACC_W         = 20;

  localparam logic signed [7:0] COS_LUT [SPS] =
    '{8'sd127, 8'sd90, 8'sd0, -8'sd90, -8'sd127, -8'sd90, 8'sd0, 8'sd90};
  localparam logic signed [7:0] SIN_LUT [SPS] =
    '{8'sd0, 8'sd90, 8'sd127, 8'sd90, 8'sd0, -8'sd90, -8'sd127, -8'sd90};

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;
endpackage

// File: rtl/qpsk_correlator.sv
// I/Q correlator: phase counter k, carrier tables and two multiply-accumulates.
// i_sum/q_sum include the current sample so the top can decide on the k=7 cycle itself.
module qpsk_correlator
  import qpsk_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,       // sample accepted this cycle
  input  logic                    restart,  // sample is k=0 of a fresh frame
  input  logic [7:0]              sample,
  output logic                    sym_end,
  output logic signed [ACC_W-1:0] i_sum,
  output logic signed [ACC_W-1:0] q_sum
);
  logic [2:0]              k, kx;
  logic signed [8:0]       x;
  logic signed [16:0]      prod_i, prod_q;
  logic signed [ACC_W-1:0] i_acc, q_acc;

  assign kx      = restart ? 3'd0 : k;
  assign x       = 9'(sample) - 9'(MIDSCALE);
  assign prod_i  = 17'(x) * 17'(COS_LUT[kx]);
  assign prod_q  = 17'(x) * 17'(SIN_LUT[kx]);
  assign i_sum   = (restart ? '0 : i_acc) + ACC_W'(prod_i);
  assign q_sum   = (restart ? '0 : q_acc) + ACC_W'(prod_q);
  assign sym_end = en && (kx == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      i_acc <= '0;
      q_acc <= '0;
    end else if (en) begin
      k     <= kx + 3'd1;  // 3-bit wrap gives the 7 -> 0 rollover
      i_acc <= sym_end ? '0 : i_sum;
      q_acc <= sym_end ? '0 : q_sum;
    end
  end
endmodule

// File: rtl/qpsk_demod.sv
// QPSK byte demodulator: frame FSM, symbol counter and byte assembly around one correlator.
// ld with in_valid always (re)starts a frame, including back-to-back right after sample 31.
module qpsk_demod
  import qpsk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       in_valid,
  input  logic       ld,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy
);
  state_e                  state;
  logic [1:0]              n;
  logic [7:0]              byte_r;
  logic                    accept, start, sym_end, ib, qb;
  logic signed [ACC_W-1:0] i_sum, q_sum;

  assign start  = in_valid && ld;
  assign accept = in_valid && (ld || state == ACCUM);
  assign ib     = (i_sum > 0);
  assign qb     = (q_sum > 0);
  assign busy   = (state == ACCUM);

  qpsk_correlator u_corr (
    .clk     (clk),
    .rst     (rst),
    .en      (accept),
    .restart (start),
    .sample  (sample_in),
    .sym_end (sym_end),
    .i_sum   (i_sum),
    .q_sum   (q_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      n          <= '0;
      byte_r     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (start) begin
        state  <= ACCUM;
        n      <= '0;
        byte_r <= '0;
      end
      // start and sym_end are exclusive: a restart sample is always k=0
      if (sym_end) begin
        byte_r[{n, 1'b0}] <= ib;
        byte_r[{n, 1'b1}] <= qb;
        n                 <= n + 2'd1;
        if (n == 2'(SYMS_PER_BYTE - 1)) begin
          state      <= IDLE;
          data_out   <= {qb, ib, byte_r[5:0]};
          data_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_qpsk_demod.sv
// Randomised bench for qpsk_demod: frame-level reference model plus per-cycle output comparison.
module tb_qpsk_demod;
  logic       clk = 1'b0;
  logic       rst, in_valid, ld;
  logic [7:0] sample_in, data_out;
  logic       data_valid, busy;

  int n_chk  = 0;
  int n_fail = 0;

  localparam int COSL [8] = '{127, 90, 0, -90, -127, -90, 0, 90};
  localparam int SINL [8] = '{0, 90, 127, 90, 0, -90, -127, -90};

  qpsk_demod dut (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (sample_in),
    .in_valid   (in_valid),
    .ld         (ld),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Waveform for byte b: symbol n carries +/-cos on I and +/-sin on Q.
  function automatic logic [7:0] gen(input logic [7:0] b, input int idx, input bit flat);
    real pi, ph, a, c, r;
    int  nn, kk;
    if (flat) return 8'd128;
    pi = 3.14159265358979;
    nn = idx / 8;
    kk = idx % 8;
    ph = 2.0 * pi * kk / 8.0;
    a  = b[2*nn]   ? 1.0 : -1.0;
    c  = b[2*nn+1] ? 1.0 : -1.0;
    r  = 44.0 * (a * $cos(ph) + c * $sin(ph));
    return 8'(128 + int'(r));
  endfunction

  int fbuf [32];
  function automatic logic [7:0] decode();
    logic [7:0] b;
    int i, q, x;
    b = '0;
    for (int s = 0; s < 4; s++) begin
      i = 0;
      q = 0;
      for (int k = 0; k < 8; k++) begin
        x = fbuf[s*8+k] - 128;
        i += x * COSL[k];
        q += x * SINL[k];
      end
      b[2*s]   = (i > 0);
      b[2*s+1] = (q > 0);
    end
    return b;
  endfunction

  // Reference model: gathers the samples of the current frame, decodes on the 32nd.
  int         mbuf [32];
  int         mcnt = 0;
  bit         mact = 0;
  bit         exp_dv = 0, exp_busy = 0;
  logic [7:0] exp_do = '0;
  int         acc_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      mact   = 0;
      mcnt   = 0;
      exp_dv = 0;
      exp_do = '0;
    end else begin
      exp_dv = 0;
      if (in_valid) begin
        acc_cnt++;
        if (ld) begin
          mact = 1;
          mcnt = 0;
        end
        if (mact) begin
          mbuf[mcnt] = int'(sample_in);
          mcnt++;
          if (mcnt == 32) begin
            for (int j = 0; j < 32; j++) fbuf[j] = mbuf[j];
            exp_do = decode();
            exp_dv = 1;
            mact   = 0;
          end
        end
      end
    end
    exp_busy = mact;
  end

  int         pulses = 0;
  logic [7:0] last_do = '0;
  int         pulse_acc [$];

  always @(posedge clk) begin
    #2;
    chk("data_valid", 32'(data_valid), 32'(exp_dv));
    chk("data_out", 32'(data_out), 32'(exp_do));
    chk("busy", 32'(busy), 32'(exp_busy));
    if (data_valid) begin
      pulses++;
      last_do = data_out;
      pulse_acc.push_back(acc_cnt);
    end
  end

  task automatic drv(input logic [7:0] s, input logic v, input logic l, input logic r);
    @(negedge clk);
    sample_in = s;
    in_valid  = v;
    ld        = l;
    rst       = r;
  endtask

  task automatic idle(input int cyc);
    for (int c = 0; c < cyc; c++) drv(8'($urandom), 1'b0, 1'($urandom), 1'b0);
  endtask

  // Sends the first nsamp samples of byte b, with gaps stall cycles per symbol.
  task automatic send(input logic [7:0] b, input int nsamp, input int gaps, input bit flat);
    int pos [3];
    for (int idx = 0; idx < nsamp; idx++) begin
      if (idx % 8 == 0)
        for (int g = 0; g < 3; g++) pos[g] = (g < gaps) ? int'($urandom_range(0, 7)) : -1;
      for (int g = 0; g < 3; g++)
        if (pos[g] == idx % 8) drv(8'($urandom), 1'b0, 1'($urandom), 1'b0);
      drv(gen(b, idx, flat), 1'b1, idx == 0, 1'b0);
    end
  endtask

  task automatic scen(input string nm, input int p0, input int np, input logic [7:0] b);
    idle(3);
    chk({nm, "_pulses"}, 32'(pulses - p0), 32'(np));
    if (np > 0) chk({nm, "_byte"}, 32'(last_do), 32'(b));
  endtask

  int p0;
  logic [7:0] rb;

  initial begin
    rst = 1'b1; in_valid = 1'b0; ld = 1'b0; sample_in = '0;
    // Hand-computed pins on the stimulus generator and the model decoder.
    chk("pin_gen_k0", 32'(gen(8'hFF, 0, 0)), 32'd172);
    chk("pin_gen_k1", 32'(gen(8'hFF, 1, 0)), 32'd190);
    chk("pin_gen_k4", 32'(gen(8'hFF, 4, 0)), 32'd84);
    for (int j = 0; j < 32; j++) fbuf[j] = int'(gen(8'hA5, j, 0));
    chk("pin_decode_a5", 32'(decode()), 32'hA5);
    for (int j = 0; j < 32; j++) fbuf[j] = 128;
    chk("pin_decode_flat", 32'(decode()), 32'h00);

    drv(8'h00, 1'b1, 1'b1, 1'b1);
    drv(8'h00, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #3;
    chk("reset_do", 32'(data_out), 32'h00);
    chk("reset_dv", 32'(data_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    idle(2);

    p0 = pulses; send(8'hFF, 32, 0, 0); scen("ff", p0, 1, 8'hFF);
    p0 = pulses; send(8'h00, 32, 0, 1); scen("flat", p0, 1, 8'h00);
    p0 = pulses; send(8'hA5, 32, 3, 0); scen("a5_stall", p0, 1, 8'hA5);

    p0 = pulses;
    send(8'h3C, 13, 0, 0);
    send(8'hC3, 32, 0, 0);
    scen("resync", p0, 1, 8'hC3);

    p0 = pulses;
    send(8'h77, 20, 0, 0);
    drv(gen(8'h77, 20, 0), 1'b1, 1'b0, 1'b1);
    @(posedge clk); #3;
    chk("rst_busy", 32'(busy), 32'h0);
    send(8'h5A, 32, 0, 0);
    scen("rst_mid", p0, 1, 8'h5A);

    p0 = pulses;
    pulse_acc.delete();
    send(8'h12, 32, 0, 0);
    send(8'hED, 32, 0, 0);
    scen("b2b", p0, 2, 8'hED);
    if (pulse_acc.size() == 2) chk("b2b_spacing", 32'(pulse_acc[1] - pulse_acc[0]), 32'd32);
    else chk("b2b_count", 32'(pulse_acc.size()), 32'd2);

    // Random frames: random bytes, stalls, aborted frames and stray resets.
    for (int f = 0; f < 40; f++) begin
      rb = 8'($urandom);
      case ($urandom_range(0, 5))
        0: send(rb, int'($urandom_range(1, 31)), int'($urandom_range(0, 3)), 0);
        1: begin
          send(rb, int'($urandom_range(1, 31)), 0, 0);
          drv(8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        default: send(rb, 32, int'($urandom_range(0, 3)), 0);
      endcase
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
